// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle instruction sequencer that owns the program
// counter. It fetches an instruction over a req/ack handshake, decodes its
// branch/jump class, starts execute, then holds the branch controls and the
// registered ALU flags steady while the next-address unit resolves. The
// resolved address is then loaded into the PC.
//
// Handshakes:
//   imem_req/imem_ack : imem_req is high for every FETCH cycle. The
//                       instruction is taken in the cycle imem_ack is high.
//                       imem_ack is ignored outside FETCH.
//   ex_start/ex_done  : ex_start pulses for the first EXEC cycle only.
//                       ex_done is accepted in any EXEC cycle, including the
//                       first, and is ignored outside EXEC.
//
// Ports:
//   clk, reset (async, active-low), start
//   imem_req, imem_addr, imem_ack, imem_rdata   instruction fetch
//   ex_start, ex_done, ALU flags in             execute stage
//   zero_q/carry_q/msb_q/overflow_q, brtype, counter_selector,
//   branch_label, jmp_label, incr_pc            next-address unit
//   pc, ra_we, ra_data, halted, retired         status and link register
//   fsm_state                                   debug view of the FSM state
module pc_sequencer #(
  parameter logic [31:0] START_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ex_start,
  input  logic        ex_done,
  input  logic        zero_flag,
  input  logic        carry_flag,
  input  logic        msb,
  input  logic        overflow,
  output logic        zero_q,
  output logic        carry_q,
  output logic        msb_q,
  output logic        overflow_q,
  output logic [3:0]  brtype,
  output logic [1:0]  counter_selector,
  output logic [15:0] branch_label,
  output logic [25:0] jmp_label,
  output logic [31:0] pc,
  input  logic [31:0] incr_pc,
  output logic        ra_we,
  output logic [31:0] ra_data,
  output logic        halted,
  output logic [31:0] retired,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    NEXT   = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] instr;
  logic        is_jal;
  logic [5:0]  opcode;

  assign opcode    = instr[31:26];
  assign imem_addr = pc;
  // Link value tracks the current PC; during NEXT that is the JAL's own PC.
  assign ra_data   = pc + 32'd1;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      pc               <= START_PC;
      instr            <= 32'h0;
      is_jal           <= 1'b0;
      brtype           <= 4'hF;
      counter_selector <= 2'd0;
      branch_label     <= 16'h0;
      jmp_label        <= 26'h0;
      zero_q           <= 1'b0;
      carry_q          <= 1'b0;
      msb_q            <= 1'b0;
      overflow_q       <= 1'b0;
      imem_req         <= 1'b0;
      ex_start         <= 1'b0;
      ra_we            <= 1'b0;
      halted           <= 1'b0;
      retired          <= 32'h0;
    end else begin
      // Single-cycle pulses default low.
      ex_start <= 1'b0;
      ra_we    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            instr    <= imem_rdata;
            imem_req <= 1'b0;
            state    <= DECODE;
          end
        end
        DECODE: begin
          // Labels are republished here so every control output changes
          // only at a DECODE edge.
          branch_label <= instr[15:0];
          jmp_label    <= instr[25:0];
          is_jal       <= 1'b0;
          ex_start     <= 1'b1;
          state        <= EXEC;
          casez (opcode)
            6'b01????: begin
              brtype           <= opcode[3:0];
              counter_selector <= 2'd0;
            end
            6'b100000: begin
              brtype           <= 4'hF;
              counter_selector <= 2'd1;
            end
            6'b100001: begin
              brtype           <= 4'hF;
              counter_selector <= 2'd1;
              is_jal           <= 1'b1;
            end
            6'b100010: begin
              brtype           <= 4'hF;
              counter_selector <= 2'd2;
            end
            6'b111111: begin
              ex_start <= 1'b0;
              halted   <= 1'b1;
              state    <= HALT;
            end
            default: begin
              brtype           <= 4'hF;
              counter_selector <= 2'd0;
            end
          endcase
        end
        EXEC: begin
          if (ex_done) begin
            zero_q     <= zero_flag;
            carry_q    <= carry_flag;
            msb_q      <= msb;
            overflow_q <= overflow;
            ra_we      <= is_jal;
            state      <= NEXT;
          end
        end
        NEXT: begin
          pc       <= incr_pc;
          retired  <= retired + 32'd1;
          imem_req <= 1'b1;
          state    <= FETCH;
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: a table of directed instruction records, a few
// hand-written multi-cycle sequences (reset mid-execute, halt, link wrap) and
// a randomized run checked against a small reference model of the decode
// rules and PC/retired bookkeeping.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ex_start;
  logic        ex_done;
  logic        zero_flag, carry_flag, msb, overflow;
  logic        zero_q, carry_q, msb_q, overflow_q;
  logic [3:0]  brtype;
  logic [1:0]  counter_selector;
  logic [15:0] branch_label;
  logic [25:0] jmp_label;
  logic [31:0] pc;
  logic [31:0] incr_pc;
  logic        ra_we;
  logic [31:0] ra_data;
  logic        halted;
  logic [31:0] retired;
  logic [2:0]  fsm_state;

  pc_sequencer #(.START_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ex_start(ex_start), .ex_done(ex_done),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .msb(msb),
    .overflow(overflow), .zero_q(zero_q), .carry_q(carry_q), .msb_q(msb_q),
    .overflow_q(overflow_q), .brtype(brtype),
    .counter_selector(counter_selector), .branch_label(branch_label),
    .jmp_label(jmp_label), .pc(pc), .incr_pc(incr_pc), .ra_we(ra_we),
    .ra_data(ra_data), .halted(halted), .retired(retired),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_retired;

  typedef struct {
    logic [31:0] instr;
    int          ack_dly;
    int          done_dly;
    logic [3:0]  flags;     // {zero, carry, msb, overflow}
    logic [31:0] next_pc;
    bit          spur;      // drive ex_done during FETCH
    bit          chk_br;    // brtype is defined for this class
    logic [3:0]  exp_br;
    logic [1:0]  exp_cs;
    bit          exp_jal;
    logic [31:0] exp_ra;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_flags();
    {zero_flag, carry_flag, msb, overflow} = 4'($urandom);
  endtask

  task automatic check_reset_vals();
    chk("rst_imem_req", imem_req, 0);
    chk("rst_ex_start", ex_start, 0);
    chk("rst_ra_we", ra_we, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_brtype", brtype, 4'hF);
    chk("rst_csel", counter_selector, 0);
    chk("rst_flags", {zero_q, carry_q, msb_q, overflow_q}, 0);
    chk("rst_labels", {branch_label, jmp_label}, 0);
  endtask

  // Decode rules written from the opcode classes.
  function automatic vec_t model_vec(input logic [31:0] instr,
                                     input logic [31:0] cur_pc);
    vec_t v;
    int   opc;
    opc        = int'(instr[31:26]);
    v.instr    = instr;
    v.ack_dly  = 0;
    v.done_dly = 0;
    v.flags    = 4'h0;
    v.next_pc  = 32'h0;
    v.spur     = 1'b0;
    v.chk_br   = 1'b0;
    v.exp_br   = 4'hF;
    v.exp_cs   = 2'd0;
    v.exp_jal  = 1'b0;
    v.exp_ra   = cur_pc + 32'd1;
    if (opc >= 16 && opc < 32) begin
      v.chk_br = 1'b1;
      v.exp_br = 4'(opc - 16);
    end else if (opc == 32) begin
      v.exp_cs = 2'd1;
    end else if (opc == 33) begin
      v.exp_cs  = 2'd1;
      v.exp_jal = 1'b1;
    end else if (opc == 34) begin
      v.exp_cs = 2'd2;
    end else begin
      v.chk_br = 1'b1;
    end
    return v;
  endfunction

  // Driver: runs one non-HALT instruction starting with the DUT in FETCH.
  task automatic run_instr(input vec_t v);
    int cycles;
    cycles = 0;
    for (int k = 0; k <= v.ack_dly; k++) begin
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, m_pc);
      chk("fetch_no_ex_start", ex_start, 0);
      imem_ack   = (k == v.ack_dly);
      imem_rdata = (k == v.ack_dly) ? v.instr : $urandom;
      ex_done    = v.spur;
      rand_flags();
      step(); cycles++;
    end
    // DECODE: junk on ack must be ignored.
    imem_ack   = 1'($urandom);
    imem_rdata = $urandom;
    ex_done    = 1'b0;
    chk("decode_req_low", imem_req, 0);
    chk("decode_no_ex_start", ex_start, 0);
    step(); cycles++;
    for (int k = 0; k <= v.done_dly; k++) begin
      chk("exec_ex_start", ex_start, (k == 0) ? 1 : 0);
      chk("exec_csel", counter_selector, v.exp_cs);
      if (v.chk_br) chk("exec_brtype", brtype, v.exp_br);
      chk("exec_branch_label", branch_label, v.instr[15:0]);
      chk("exec_jmp_label", jmp_label, v.instr[25:0]);
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      ex_done    = (k == v.done_dly);
      if (k == v.done_dly) {zero_flag, carry_flag, msb, overflow} = v.flags;
      else rand_flags();
      step(); cycles++;
    end
    // NEXT
    ex_done  = 1'b0;
    imem_ack = 1'b0;
    rand_flags();
    incr_pc  = v.next_pc;
    chk("next_flags", {zero_q, carry_q, msb_q, overflow_q}, v.flags);
    chk("next_ra_we", ra_we, v.exp_jal);
    if (v.exp_jal) chk("next_ra_data", ra_data, v.exp_ra);
    chk("next_ex_start", ex_start, 0);
    chk("next_pc_hold", pc, m_pc);
    #5;  // just past the falling edge inside NEXT
    chk("negedge_csel", counter_selector, v.exp_cs);
    if (v.chk_br) chk("negedge_brtype", brtype, v.exp_br);
    chk("negedge_flags", {zero_q, carry_q, msb_q, overflow_q}, v.flags);
    step(); cycles++;
    m_pc      = v.next_pc;
    m_retired = m_retired + 32'd1;
    chk("after_pc", pc, m_pc);
    chk("after_retired", retired, m_retired);
    chk("after_ra_we", ra_we, 0);
    chk("cycles", 32'(cycles), 32'(4 + v.ack_dly + v.done_dly));
  endtask

  initial begin
    // Table: {instr, ack, done, flags, next_pc, spur, chk_br, br, cs, jal, ra}
    vecs[0] = '{32'h0000_0000, 0, 0, 4'b0000, 32'h0000_0001, 0, 1, 4'hF, 2'd0, 0, 32'h0};
    vecs[1] = '{32'h4400_1234, 0, 0, 4'b1000, 32'h0000_0010, 0, 1, 4'h1, 2'd0, 0, 32'h0};
    vecs[2] = '{32'h840A_BCDE, 0, 0, 4'b0101, 32'h0000_0020, 0, 0, 4'h0, 2'd1, 1, 32'h0000_0011};
    vecs[3] = '{32'h8800_0005, 1, 1, 4'b0010, 32'h0000_0030, 0, 0, 4'h0, 2'd2, 0, 32'h0};
    vecs[4] = '{32'h1400_00FF, 3, 2, 4'b1111, 32'h0000_0031, 1, 1, 4'hF, 2'd0, 0, 32'h0};
    vecs[5] = '{32'h7C00_0ABC, 2, 0, 4'b0110, 32'h0000_0040, 0, 1, 4'hF, 2'd0, 0, 32'h0};

    reset = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    ex_done = 1'b0; incr_pc = 32'h0;
    {zero_flag, carry_flag, msb, overflow} = 4'h0;
    m_pc = 32'h0; m_retired = 32'h0;
    step(); step();
    check_reset_vals();
    reset = 1'b1;
    step(); step();
    chk("idle_no_req", imem_req, 0);
    start = 1'b1;
    step();
    start = 1'b0;

    foreach (vecs[i]) run_instr(vecs[i]);

    // Reset asserted in the middle of EXEC.
    chk("mid_fetch_req", imem_req, 1);
    imem_ack = 1'b1; imem_rdata = 32'h4800_0000;
    step();
    imem_ack = 1'b0;
    step();
    chk("mid_exec_ex_start", ex_start, 1);
    #2 reset = 1'b0;
    #1 check_reset_vals();
    step();
    reset = 1'b1;
    m_pc = 32'h0; m_retired = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_idle_req", imem_req, 0);
      chk("post_reset_idle_pc", pc, 0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 0);

    // Randomized instructions against the model.
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      logic [31:0] ins;
      int cls;
      int opc;
      cls = $urandom_range(0, 4);
      case (cls)
        0: opc = 16 + $urandom_range(0, 15);
        1: opc = 32;
        2: opc = 33;
        3: opc = 34;
        default: begin
          opc = $urandom_range(0, 26);
          if (opc >= 16) opc = opc + 19;
        end
      endcase
      ins = {6'(opc), 26'($urandom)};
      v = model_vec(ins, m_pc);
      v.ack_dly  = $urandom_range(0, 3);
      v.done_dly = $urandom_range(0, 3);
      v.flags    = 4'($urandom);
      v.next_pc  = (n == 39) ? 32'hFFFF_FFFF : $urandom;
      v.spur     = 1'($urandom);
      run_instr(v);
    end

    // JAL at the top of the address space: link value wraps to zero.
    begin
      vec_t v;
      v = model_vec(32'h8400_0123, m_pc);
      v.next_pc = 32'h0000_0100;
      v.flags   = 4'b1001;
      chk("wrap_model_ra", v.exp_ra, 32'h0);
      run_instr(v);
    end

    // HALT: no execute, no retire, start ignored.
    chk("halt_fetch_req", imem_req, 1);
    imem_ack = 1'b1; imem_rdata = 32'hFC00_0000;
    step();
    imem_ack = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("halt_halted", halted, 1);
      chk("halt_req", imem_req, 0);
      chk("halt_ex_start", ex_start, 0);
      chk("halt_pc", pc, m_pc);
      chk("halt_retired", retired, m_retired);
      start    = 1'($urandom);
      imem_ack = 1'($urandom);
      ex_done  = 1'($urandom);
      step();
    end
    start = 1'b0; imem_ack = 1'b0; ex_done = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
